dvp_capture_multi: RTL and testbench

- Parametrised successor to the single-mode OV7670 byte-pair capture.
- Assembles BYTES_PER_PIX camera bytes per pixel from a DVP bus (vsync/href/d), with runtime horizontal/vertical decimation, frame-aligned enable, and per-line/per-frame geometry checking.
- Sits between the camera pins (pclk domain) and the pixel FIFO/frame-buffer writer.
- Outputs sof/eol/frame_done markers and error pulses for the status registers.

---
 rtl/dvp_capture_multi.sv | 242 ++++++++++++++++++++++++
 tb/tb_dvp_capture_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_multi.sv
// DVP camera capture: assembles BYTES_PER_PIX bytes per pixel, applies runtime
// decimation on frame boundaries and flags per-line / per-frame geometry faults.
module dvp_capture_multi #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int CNT_W         = 11,
  parameter int DEC_W         = 3
) (
  input  logic                            pclk,
  input  logic                            rst,
  input  logic                            enable_capture,
  input  logic [DEC_W-1:0]                dec_x,
  input  logic [DEC_W-1:0]                dec_y,
  input  logic [CNT_W-1:0]                exp_width,
  input  logic                            vsync,
  input  logic                            href,
  input  logic [DATA_W-1:0]               d,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pixel_data,
  output logic                            pixel_valid,
  output logic                            sof,
  output logic                            eol,
  output logic                            frame_done,
  output logic [CNT_W-1:0]                frame_lines,
  output logic                            line_err,
  output logic                            partial_err,
  output logic                            busy
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int BC_W  = 2;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    VBLANK = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  logic             vsync_prev_r, href_prev_r;
  logic [BC_W-1:0]  byte_cnt_r;
  logic [PIX_W-1:0] shift_r;
  logic [CNT_W-1:0] x_r, y_r, exp_width_r;
  logic [DEC_W-1:0] x_phase_r, y_phase_r, dec_x_r, dec_y_r;
  logic             sof_armed_r;

  logic             pixel_valid_r, sof_r, eol_r, frame_done_r, line_err_r, partial_err_r, busy_r;
  logic [PIX_W-1:0] pixel_data_r;
  logic [CNT_W-1:0] frame_lines_r;

  logic             vs_rise_s, vs_fall_s, href_fall_s;
  logic             frame_start_s, frame_end_s;
  logic             sample_s, pix_done_s, keep_s, close_s, eol_s;
  logic [PIX_W-1:0] pixel_next_s;
  logic [CNT_W-1:0] x_inc_s, y_inc_s;
  logic [DEC_W-1:0] x_phase_next_s, y_phase_next_s;

  // Event decode and next-state selection
  always_comb begin
    state_next_s  = state_r;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    vs_rise_s     = vsync & ~vsync_prev_r;
    vs_fall_s     = ~vsync & vsync_prev_r;
    href_fall_s   = href_prev_r & ~href;

    case (state_r)
      IDLE: begin
        if (enable_capture) begin
          state_next_s = SYNC;
        end else begin
          state_next_s = IDLE;
        end
      end
      SYNC: begin
        if (vsync) begin
          state_next_s = VBLANK;
        end else begin
          state_next_s = SYNC;
        end
      end
      VBLANK: begin
        if (!enable_capture) begin
          state_next_s = IDLE;
        end else if (vs_fall_s) begin
          state_next_s  = ACTIVE;
          frame_start_s = 1'b1;
        end else begin
          state_next_s = VBLANK;
        end
      end
      ACTIVE: begin
        // A disable request never truncates a frame; it is acted on at vsync.
        if (vs_rise_s) begin
          frame_end_s  = 1'b1;
          state_next_s = enable_capture ? VBLANK : IDLE;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath helpers: byte sampling, pixel completion, line closure
  always_comb begin
    sample_s     = (state_r == ACTIVE) && href && !vsync;
    pix_done_s   = sample_s && (byte_cnt_r == BC_LAST);
    keep_s       = (x_phase_r == {DEC_W{1'b0}}) && (y_phase_r == {DEC_W{1'b0}});
    pixel_next_s = (shift_r << DATA_W) | PIX_W'(d);
    // An open line at vsync rise is closed like an href fall, minus the eol.
    close_s      = (state_r == ACTIVE) && (href_fall_s || (vs_rise_s && href));
    eol_s        = close_s && !vs_rise_s && (y_phase_r == {DEC_W{1'b0}});

    if (x_r == {CNT_W{1'b1}}) begin
      x_inc_s = x_r;
    end else begin
      x_inc_s = x_r + CNT_W'(1);
    end
    if (y_r == {CNT_W{1'b1}}) begin
      y_inc_s = y_r;
    end else begin
      y_inc_s = y_r + CNT_W'(1);
    end
    if (x_phase_r == dec_x_r) begin
      x_phase_next_s = {DEC_W{1'b0}};
    end else begin
      x_phase_next_s = x_phase_r + DEC_W'(1);
    end
    if (y_phase_r == dec_y_r) begin
      y_phase_next_s = {DEC_W{1'b0}};
    end else begin
      y_phase_next_s = y_phase_r + DEC_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture datapath, counters and registered outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_prev_r  <= 1'b0;
      href_prev_r   <= 1'b0;
      byte_cnt_r    <= {BC_W{1'b0}};
      shift_r       <= {PIX_W{1'b0}};
      x_r           <= {CNT_W{1'b0}};
      y_r           <= {CNT_W{1'b0}};
      x_phase_r     <= {DEC_W{1'b0}};
      y_phase_r     <= {DEC_W{1'b0}};
      dec_x_r       <= {DEC_W{1'b0}};
      dec_y_r       <= {DEC_W{1'b0}};
      exp_width_r   <= {CNT_W{1'b0}};
      sof_armed_r   <= 1'b0;
      pixel_data_r  <= {PIX_W{1'b0}};
      pixel_valid_r <= 1'b0;
      sof_r         <= 1'b0;
      eol_r         <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_lines_r <= {CNT_W{1'b0}};
      line_err_r    <= 1'b0;
      partial_err_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      vsync_prev_r  <= vsync;
      href_prev_r   <= href;
      pixel_valid_r <= 1'b0;
      sof_r         <= 1'b0;
      eol_r         <= 1'b0;
      frame_done_r  <= 1'b0;
      line_err_r    <= 1'b0;
      partial_err_r <= 1'b0;
      busy_r        <= (state_next_s == VBLANK) || (state_next_s == ACTIVE);

      if (frame_start_s) begin
        dec_x_r     <= dec_x;
        dec_y_r     <= dec_y;
        exp_width_r <= exp_width;
        x_r         <= {CNT_W{1'b0}};
        y_r         <= {CNT_W{1'b0}};
        x_phase_r   <= {DEC_W{1'b0}};
        y_phase_r   <= {DEC_W{1'b0}};
        byte_cnt_r  <= {BC_W{1'b0}};
        sof_armed_r <= 1'b1;
      end else begin
        if (sample_s) begin
          shift_r <= pixel_next_s;
          if (pix_done_s) begin
            byte_cnt_r <= {BC_W{1'b0}};
            x_r        <= x_inc_s;
            x_phase_r  <= x_phase_next_s;
            if (keep_s) begin
              pixel_data_r  <= pixel_next_s;
              pixel_valid_r <= 1'b1;
              sof_r         <= sof_armed_r;
              sof_armed_r   <= 1'b0;
            end
          end else begin
            byte_cnt_r <= byte_cnt_r + BC_W'(1);
          end
        end
        // Sampling needs href high and closure needs it low or vsync high, so
        // the two branches never fire together.
        if (close_s) begin
          partial_err_r <= (byte_cnt_r != {BC_W{1'b0}});
          line_err_r    <= (x_r != exp_width_r);
          eol_r         <= eol_s;
          y_r           <= y_inc_s;
          y_phase_r     <= y_phase_next_s;
          x_r           <= {CNT_W{1'b0}};
          x_phase_r     <= {DEC_W{1'b0}};
          byte_cnt_r    <= {BC_W{1'b0}};
        end
        if (frame_end_s) begin
          frame_done_r  <= 1'b1;
          frame_lines_r <= close_s ? y_inc_s : y_r;
        end
      end
    end
  end

  assign pixel_data  = pixel_data_r;
  assign pixel_valid = pixel_valid_r;
  assign sof         = sof_r;
  assign eol         = eol_r;
  assign frame_done  = frame_done_r;
  assign frame_lines = frame_lines_r;
  assign line_err    = line_err_r;
  assign partial_err = partial_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_dvp_capture_multi.sv
// Directed bench for dvp_capture_multi: a 2-byte-per-pixel build and a
// 3-byte-per-pixel build share one DVP stimulus stream.
module tb_dvp_capture_multi;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable_capture;
  logic [2:0]  dec_x, dec_y;
  logic [10:0] exp_width;
  logic        vsync, href;
  logic [7:0]  d;

  logic [15:0] pixel_data;
  logic        pixel_valid, sof, eol, frame_done, line_err, partial_err, busy;
  logic [10:0] frame_lines;

  logic [23:0] pixel_data3;
  logic        pixel_valid3, sof3, eol3, frame_done3, line_err3, partial_err3, busy3;
  logic [10:0] frame_lines3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  dvp_capture_multi #(.DATA_W(8), .BYTES_PER_PIX(2), .CNT_W(11), .DEC_W(3)) dut (
    .pclk(pclk), .rst(rst), .enable_capture(enable_capture),
    .dec_x(dec_x), .dec_y(dec_y), .exp_width(exp_width),
    .vsync(vsync), .href(href), .d(d),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .sof(sof), .eol(eol),
    .frame_done(frame_done), .frame_lines(frame_lines), .line_err(line_err),
    .partial_err(partial_err), .busy(busy)
  );

  dvp_capture_multi #(.DATA_W(8), .BYTES_PER_PIX(3), .CNT_W(11), .DEC_W(3)) dut3 (
    .pclk(pclk), .rst(rst), .enable_capture(enable_capture),
    .dec_x(dec_x), .dec_y(dec_y), .exp_width(exp_width),
    .vsync(vsync), .href(href), .d(d),
    .pixel_data(pixel_data3), .pixel_valid(pixel_valid3), .sof(sof3), .eol(eol3),
    .frame_done(frame_done3), .frame_lines(frame_lines3), .line_err(line_err3),
    .partial_err(partial_err3), .busy(busy3)
  );

  // Event monitor: cumulative counts plus a log of every emitted pixel
  int          n_valid = 0, n_sof = 0, n_eol = 0, n_fd = 0, n_lerr = 0, n_perr = 0;
  int          n_valid3 = 0, n_misc3 = 0;
  logic [15:0] pix_log [0:255];
  logic        sof_log [0:255];
  logic [23:0] first_pix3;
  logic        first_sof3;

  always @(negedge pclk) begin
    if (pixel_valid) begin
      pix_log[n_valid[7:0]] = pixel_data;
      sof_log[n_valid[7:0]] = sof;
      n_valid++;
    end
    if (sof)         n_sof++;
    if (eol)         n_eol++;
    if (frame_done)  n_fd++;
    if (line_err)    n_lerr++;
    if (partial_err) n_perr++;
    if (pixel_valid3) begin
      if (n_valid3 == 0) begin
        first_pix3 = pixel_data3;
        first_sof3 = sof3;
      end
      n_valid3++;
    end
    if (eol3 || frame_done3 || line_err3 || partial_err3 || busy3 || (frame_lines3 != 11'd0)) n_misc3++;
  end

  int b_valid, b_sof, b_eol, b_fd, b_lerr, b_perr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic mark();
    b_valid = n_valid; b_sof = n_sof; b_eol = n_eol;
    b_fd = n_fd; b_lerr = n_lerr; b_perr = n_perr;
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] start);
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      d = start + 8'(i);
      cyc(1);
    end
    href = 1'b0;
    d = 8'h00;
    cyc(3);
  endtask

  initial begin
    rst = 1'b1; enable_capture = 1'b0; dec_x = 3'd0; dec_y = 3'd0;
    exp_width = 11'd4; vsync = 1'b0; href = 1'b0; d = 8'h00;
    cyc(3);
    check_eq("rst_valid", 64'(pixel_valid), 64'd0);
    check_eq("rst_data", 64'(pixel_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_lines", 64'(frame_lines), 64'd0);
    rst = 1'b0;

    // Clean frame: 3 lines of bytes 01..08, no decimation
    enable_capture = 1'b1;
    cyc(2);
    vsync = 1'b1; cyc(3);
    check_eq("vblank_busy", 64'(busy), 64'd1);
    mark();
    vsync = 1'b0; cyc(2);
    for (int l = 0; l < 3; l++) send_line(8, 8'h01);
    vsync = 1'b1; cyc(3);
    check_eq("clean_valids", 64'(n_valid - b_valid), 64'd12);
    check_eq("clean_first", 64'(pix_log[b_valid]), 64'h0102);
    check_eq("clean_first_sof", 64'(sof_log[b_valid]), 64'd1);
    check_eq("clean_last", 64'(pix_log[b_valid + 11]), 64'h0708);
    check_eq("clean_sofs", 64'(n_sof - b_sof), 64'd1);
    check_eq("clean_eols", 64'(n_eol - b_eol), 64'd3);
    check_eq("clean_done", 64'(n_fd - b_fd), 64'd1);
    check_eq("clean_lines", 64'(frame_lines), 64'd3);
    check_eq("clean_lerr", 64'(n_lerr - b_lerr), 64'd0);
    check_eq("clean_perr", 64'(n_perr - b_perr), 64'd0);
    check_eq("bpp3_first", 64'(first_pix3), 64'h010203);
    check_eq("bpp3_first_sof", 64'(first_sof3), 64'd1);

    // Decimation 1-of-2 in both axes: 4 lines x 4 pixels
    mark();
    dec_x = 3'd1; dec_y = 3'd1;
    vsync = 1'b0; cyc(2);
    dec_x = 3'd0; dec_y = 3'd0;
    for (int l = 0; l < 4; l++) send_line(8, 8'h10);
    vsync = 1'b1; cyc(3);
    check_eq("dec_valids", 64'(n_valid - b_valid), 64'd4);
    check_eq("dec_first", 64'(pix_log[b_valid]), 64'h1011);
    check_eq("dec_second", 64'(pix_log[b_valid + 1]), 64'h1415);
    check_eq("dec_third", 64'(pix_log[b_valid + 2]), 64'h1011);
    check_eq("dec_eols", 64'(n_eol - b_eol), 64'd2);
    check_eq("dec_lines", 64'(frame_lines), 64'd4);
    check_eq("dec_lerr", 64'(n_lerr - b_lerr), 64'd0);

    // Geometry errors: 7-byte line, then vsync rising with href high
    mark();
    vsync = 1'b0; cyc(2);
    send_line(7, 8'h20);
    check_eq("geo_valids", 64'(n_valid - b_valid), 64'd3);
    check_eq("geo_perr", 64'(n_perr - b_perr), 64'd1);
    check_eq("geo_lerr", 64'(n_lerr - b_lerr), 64'd1);
    check_eq("geo_eol", 64'(n_eol - b_eol), 64'd1);
    href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h30 + 8'(i);
      cyc(1);
    end
    vsync = 1'b1; cyc(1);
    href = 1'b0; cyc(2);
    check_eq("geo_open_lerr", 64'(n_lerr - b_lerr), 64'd2);
    check_eq("geo_open_perr", 64'(n_perr - b_perr), 64'd1);
    check_eq("geo_open_eol", 64'(n_eol - b_eol), 64'd1);
    check_eq("geo_done", 64'(n_fd - b_fd), 64'd1);
    check_eq("geo_lines", 64'(frame_lines), 64'd2);

    // Disable mid-frame: frame completes, then IDLE
    mark();
    vsync = 1'b0; cyc(2);
    send_line(8, 8'h30);
    enable_capture = 1'b0;
    send_line(8, 8'h38);
    vsync = 1'b1; cyc(3);
    check_eq("dis_valids", 64'(n_valid - b_valid), 64'd8);
    check_eq("dis_done", 64'(n_fd - b_fd), 64'd1);
    check_eq("dis_lines", 64'(frame_lines), 64'd2);
    check_eq("dis_busy", 64'(busy), 64'd0);

    // Enable rising mid-frame: current frame ignored, next one captured
    vsync = 1'b0; cyc(2);
    mark();
    send_line(8, 8'h40);
    enable_capture = 1'b1;
    cyc(1);
    send_line(8, 8'h48);
    check_eq("en_no_output", 64'(n_valid - b_valid), 64'd0);
    check_eq("en_sync_busy", 64'(busy), 64'd0);
    vsync = 1'b1; cyc(3);
    check_eq("en_no_done", 64'(n_fd - b_fd), 64'd0);
    check_eq("en_vblank_busy", 64'(busy), 64'd1);
    vsync = 1'b0; cyc(2);
    send_line(8, 8'h50);
    vsync = 1'b1; cyc(3);
    check_eq("en_valids", 64'(n_valid - b_valid), 64'd4);
    check_eq("en_first", 64'(pix_log[b_valid]), 64'h5051);
    check_eq("en_first_sof", 64'(sof_log[b_valid]), 64'd1);
    check_eq("en_lines", 64'(frame_lines), 64'd1);

    // Three-byte packing and latency, then reset mid-line
    vsync = 1'b0; cyc(2);
    href = 1'b1;
    d = 8'hAA; cyc(1);
    d = 8'hBB; cyc(1);
    check_eq("bpp3_not_early", 64'(pixel_valid3), 64'd0);
    d = 8'hCC; cyc(1);
    check_eq("bpp3_valid", 64'(pixel_valid3), 64'd1);
    check_eq("bpp3_data", 64'(pixel_data3), 64'hAABBCC);
    d = 8'hDD; cyc(1);
    check_eq("pre_rst_valid", 64'(pixel_valid), 64'd1);
    check_eq("pre_rst_data", 64'(pixel_data), 64'hCCDD);
    href = 1'b0; rst = 1'b1; cyc(1);
    check_eq("mid_rst_valid", 64'(pixel_valid), 64'd0);
    check_eq("mid_rst_data", 64'(pixel_data), 64'd0);
    check_eq("mid_rst_eol", 64'(eol), 64'd0);
    check_eq("mid_rst_lerr", 64'(line_err), 64'd0);
    check_eq("mid_rst_perr3", 64'(partial_err3), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_lines", 64'(frame_lines), 64'd0);
    rst = 1'b0; cyc(2);
    check_eq("post_rst_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
